// File: rtl/tmds_pkg.sv
// Shared types, control-period codes and helpers for the TMDS channel encoder.
package tmds_pkg;

  typedef logic signed [4:0] tally_t;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  // Number of set bits in a byte (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/tm_choice.sv
// Transition-minimiser: maps a pixel byte to the 9-bit q_m word (bit 8 = 1 for XOR chain).
module tm_choice
  import tmds_pkg::*;
(
  input  logic [7:0] data,
  output logic [8:0] q_m
);

  logic [3:0] ones;
  logic       use_xnor;
  logic [8:0] acc;

  // Pick XOR or XNOR chaining from the byte's ones count, then build the chain LSB first.
  always_comb begin
    ones     = popcount8(data);
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !data[0]);
    acc      = '0;
    acc[0]   = data[0];
    for (int i = 1; i < 8; i++) begin
      acc[i] = use_xnor ? ~(data[i] ^ acc[i-1]) : (data[i] ^ acc[i-1]);
    end
    acc[8] = ~use_xnor;
    q_m    = acc;
  end

endmodule

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: transition-minimise in stage 1, DC-balance / control substitution in stage 2.
module tmds_channel_encoder
  import tmds_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] data_in,
  input  logic [1:0] control_in,
  input  logic       ve_in,
  output logic [9:0] tmds_out
);

  logic [8:0] q_m_c;
  logic [8:0] q_m_p1;
  logic       vld_p1;
  logic [1:0] ctrl_p1;
  tally_t     tally;
  tally_t     tally_nxt;
  tally_t     n1;
  tally_t     n0;
  tally_t     bias2;
  logic [9:0] sym_nxt;

  tm_choice u_tm_choice (
    .data (data_in),
    .q_m  (q_m_c)
  );

  // ---- stage 1: register q_m with its video-enable and control bits ----
  // Capture the transition-minimised word alongside ve/control.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      q_m_p1  <= '0;
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else begin
      q_m_p1  <= q_m_c;
      vld_p1  <= ve_in;
      ctrl_p1 <= control_in;
    end
  end

  // ---- stage 2: DC balance against the running tally, or control code ----
  // Choose the symbol form (A/B/C) and the tally update; control period zeroes the tally.
  always_comb begin
    n1        = tally_t'({1'b0, popcount8(q_m_p1[7:0])});
    n0        = 5'sd8 - n1;
    bias2     = tally_t'({3'b000, q_m_p1[8], 1'b0});
    sym_nxt   = '0;
    tally_nxt = '0;
    if (!vld_p1) begin
      case (ctrl_p1)
        2'b00:   sym_nxt = CTRL_00;
        2'b01:   sym_nxt = CTRL_01;
        2'b10:   sym_nxt = CTRL_10;
        default: sym_nxt = CTRL_11;
      endcase
      tally_nxt = '0;
    end else if ((tally == 5'sd0) || (n1 == n0)) begin
      sym_nxt   = {~q_m_p1[8], q_m_p1[8], q_m_p1[8] ? q_m_p1[7:0] : ~q_m_p1[7:0]};
      tally_nxt = q_m_p1[8] ? (tally + (n1 - n0)) : (tally + (n0 - n1));
    end else if (((tally > 5'sd0) && (n1 > n0)) || ((tally < 5'sd0) && (n0 > n1))) begin
      sym_nxt   = {1'b1, q_m_p1[8], ~q_m_p1[7:0]};
      tally_nxt = tally + bias2 + (n0 - n1);
    end else begin
      sym_nxt   = {1'b0, q_m_p1[8], q_m_p1[7:0]};
      tally_nxt = tally + (n1 - n0) - (5'sd2 - bias2);
    end
  end

  // Register the output symbol and running disparity.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tmds_out <= '0;
      tally    <= '0;
    end else begin
      tmds_out <= sym_nxt;
      tally    <= tally_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Directed and randomized checks of the TMDS channel encoder against hand values and a model.
module tb_tmds_channel_encoder;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [7:0] data_in;
  logic [1:0] control_in;
  logic       ve_in;
  logic [9:0] tmds_out;

  int vectors     = 0;
  int miscompares = 0;

  tmds_channel_encoder dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .data_in    (data_in),
    .control_in (control_in),
    .ve_in      (ve_in),
    .tmds_out   (tmds_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h) t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Apply one input set, clock it in, and settle 1 time unit after the edge.
  task automatic drive(input logic [7:0] d, input logic [1:0] c, input logic v);
    data_in    = d;
    control_in = c;
    ve_in      = v;
    @(posedge clk_in);
    #1;
  endtask

  // Reference encoder, integer arithmetic; updates the model disparity t.
  function automatic logic [9:0] ref_enc(input logic [7:0] d, input logic [1:0] c,
                                         input logic v, inout int t);
    int         nd, n1, n0;
    logic [8:0] q;
    logic [9:0] s;
    if (!v) begin
      t = 0;
      case (c)
        2'd0: return 10'h354;
        2'd1: return 10'h0AB;
        2'd2: return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    nd = 0;
    for (int i = 0; i < 8; i++) nd += d[i];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      if (nd > 4 || (nd == 4 && d[0] == 1'b0)) q[i] = ~(q[i-1] ^ d[i]);
      else q[i] = q[i-1] ^ d[i];
    end
    q[8] = !(nd > 4 || (nd == 4 && d[0] == 1'b0));
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += q[i];
    n0 = 8 - n1;
    if (t == 0 || n1 == n0) begin
      if (q[8]) begin s = {2'b01, q[7:0]};  t = t + n1 - n0; end
      else      begin s = {2'b10, ~q[7:0]}; t = t + n0 - n1; end
    end else if ((t > 0 && n1 > n0) || (t < 0 && n0 > n1)) begin
      s = {1'b1, q[8], ~q[7:0]};
      t = t + (q[8] ? 2 : 0) + n0 - n1;
    end else begin
      s = {1'b0, q[8], q[7:0]};
      t = t + n1 - n0 - (q[8] ? 0 : 2);
    end
    return s;
  endfunction

  logic [9:0] pend_sym;
  int         pend_t;
  int         mt;
  logic [7:0] rd;
  logic [1:0] rc;
  logic       rv;

  initial begin
    rst_n_in   = 1'b0;
    data_in    = 8'hA5;
    control_in = 2'b10;
    ve_in      = 1'b1;
    #1;
    chk("rst_async", tmds_out, 0);
    for (int i = 0; i < 3; i++) begin
      drive(8'($urandom), 2'($urandom), 1'($urandom));
      chk("rst_hold", tmds_out, 0);
      chk("rst_tally", int'(dut.tally), 0);
    end
    rst_n_in = 1'b1;

    // Cleared stage 1 looks like control 00 in stage 2.
    drive(8'h00, 2'b00, 1'b0);
    chk("post_rst", tmds_out, 10'h354);
    drive(8'h00, 2'b01, 1'b0);
    chk("ctrl00", tmds_out, 10'h354);
    drive(8'h00, 2'b10, 1'b0);
    chk("ctrl01", tmds_out, 10'h0AB);
    drive(8'h00, 2'b11, 1'b0);
    chk("ctrl10", tmds_out, 10'h154);
    drive(8'h00, 2'b00, 1'b1);
    chk("ctrl11", tmds_out, 10'h2AB);
    chk("ctrl_tally", int'(dut.tally), 0);
    drive(8'h00, 2'b00, 1'b1);
    drive(8'h00, 2'b00, 1'b1);
    // The two drives above clocked zeros 1 and 2; check zero 1 lagged by one.
    drive(8'h00, 2'b00, 1'b0);
    // Replay check order: outputs appear one drive after capture; recheck from a clean run.
    drive(8'h00, 2'b00, 1'b0);

    // Repeated zeros after a control period.
    drive(8'h00, 2'b00, 1'b1);
    drive(8'h00, 2'b00, 1'b1);
    chk("zero1", tmds_out, 10'h100);
    chk("zero1_t", int'(dut.tally), -8);
    drive(8'h00, 2'b00, 1'b1);
    chk("zero2", tmds_out, 10'h3FF);
    chk("zero2_t", int'(dut.tally), 2);
    drive(8'h00, 2'b00, 1'b0);
    chk("zero3", tmds_out, 10'h100);
    chk("zero3_t", int'(dut.tally), -6);

    // All ones after a control period.
    drive(8'hFF, 2'b00, 1'b1);
    chk("blank", tmds_out, 10'h354);
    chk("blank_t", int'(dut.tally), 0);
    drive(8'h00, 2'b00, 1'b1);
    chk("ones", tmds_out, 10'h200);
    chk("ones_t", int'(dut.tally), -8);

    // Video -> one control symbol -> video restarts the tally.
    drive(8'h00, 2'b00, 1'b0);
    chk("vid0", tmds_out, 10'h3FF);
    chk("vid0_t", int'(dut.tally), 2);
    drive(8'h00, 2'b00, 1'b1);
    chk("gap", tmds_out, 10'h354);
    drive(8'h00, 2'b00, 1'b0);
    chk("restart", tmds_out, 10'h100);
    chk("restart_t", int'(dut.tally), -8);

    // Long randomized run against the model with periodic blanking and a mid-burst reset.
    drive(8'h00, 2'b00, 1'b0);
    mt       = 0;
    pend_sym = ref_enc(8'h00, 2'b00, 1'b0, mt);
    pend_t   = mt;
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("rst_mid", tmds_out, 0);
        chk("rst_mid_t", int'(dut.tally), 0);
        drive(8'($urandom), 2'($urandom), 1'b1);
        chk("rst_mid_hold", tmds_out, 0);
        rst_n_in = 1'b1;
        mt       = 0;
        pend_sym = 10'h354;
        pend_t   = 0;
      end
      rd = 8'($urandom);
      rc = 2'($urandom);
      rv = ((i % 150) < 120);
      drive(rd, rc, rv);
      chk("rand_sym", tmds_out, pend_sym);
      chk("rand_t", int'(dut.tally), pend_t);
      chk("rand_tmag", int'((dut.tally <= 5'sd10) && (dut.tally >= -5'sd10)), 1);
      pend_sym = ref_enc(rd, rc, rv, mt);
      pend_t   = mt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tmds_channel_encoder.md
Name: tmds_channel_encoder

Overview:
- Full TMDS encoder for one HDMI/DVI channel (R, G or B) in the lighting video output path.
- Sequences the transition-minimised 9-bit stage and the DC-balance stage.
- Tracks running disparity across video periods and substitutes control-period symbols during blanking.
- Three instances sit between the pixel/sync generator and the 10:1 serialiser.

Parameters:
- none (8-bit data, 10-bit symbol fixed by TMDS)

Ports:
- clk_in  input  1  pixel clock
- rst_n_in  input  1  asynchronous, active-low reset
- data_in  input  8  pixel byte for this channel
- control_in  input  2  {C1,C0} control bits (HSYNC/VSYNC on the blue channel, 0 otherwise)
- ve_in  input  1  video enable: 1 = active pixel, 0 = control period
- tmds_out  output  10  encoded symbol, bit 0 transmitted first

Behaviour:
- Reset:
  - Async assert on rst_n_in=0: tmds_out=10'h000, tally=0, all pipeline regs=0.
  - Release synchronised by the caller.
  - Reset mid-stream discards in-flight symbols.
- Latency: 2 cycles, fixed, one symbol per clock, no stall.
- Stage 1 (cycle N): register q_m[8:0] (transition-minimised form of data_in), plus ve and control_in.
- Transition-minimised rule:
  - N1(d) = ones in data_in.
  - Choose XNOR if N1>4, or N1==4 and d[0]==0; otherwise XOR.
  - q_m[0]=d[0]; q_m[i]=d[i] XOR/XNOR q_m[i-1].
  - q_m[8]=1 for XOR, 0 for XNOR.
- Stage 2 (cycle N+1): N1 = ones in q_m[7:0], N0 = 8-N1. tally is a 5-bit signed register (range -16..+15); all arithmetic is signed 5-bit.
- Stage 2 case A (tally==0 or N1==N0):
  - tmds = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}.
  - tally += q_m8 ? (N1-N0) : (N0-N1).
- Stage 2 case B ((tally>0 and N1>N0) or (tally<0 and N0>N1)):
  - tmds = {1, q_m8, ~q_m[7:0]}.
  - tally += 2*q_m8 + (N0-N1).
- Stage 2 case C (otherwise):
  - tmds = {0, q_m8, q_m[7:0]}.
  - tally += (N1-N0) - 2*(~q_m8).
- Control period (stage-2 ve=0):
  - tally forced to 0.
  - tmds_out from the control table: 00→10'b1101010100, 01→10'b0010101011, 10→10'b0101010100, 11→10'b1010101011.
- ve transitions:
  - The first video symbol after any control symbol always starts from tally=0.
  - No guard-band insertion in this block.
- Tally magnitude never exceeds ±10 by construction. The bench checks this; wrap is not handled.

Decomposition:
- Package tmds_pkg:
  - typedef tally_t (logic signed [4:0]).
  - Localparams CTRL_00/01/10/11 (10-bit codes).
  - Function popcount8.
- Sub-module: tm_choice (existing combinational transition-minimiser, 8→9 bits), instantiated in stage 1.
- Disparity logic stays inline.

Test Plan:
- Reset: hold rst_n_in=0 with random inputs → tmds_out=0x000 immediately (async) and throughout.
- Control symbols: ve_in=0, control_in=00,01,10,11 on consecutive cycles → tmds_out=0x354, 0x0AB, 0x154, 0x2AB starting 2 cycles later; tally=0.
- Disparity on repeated zeros: after a control period, ve_in=1, data_in=0x00 three times → tmds_out 0x100 (tally -8), 0x3FF (tally +2), 0x100 (tally -6).
- All ones: after a control period, ve_in=1, data_in=0xFF → q_m=0x0FF, tmds_out=0x200, tally -8.
- Video→control→video: stream 0x00, drop ve_in for 1 cycle, resume with 0x00 → the post-control symbol is 0x100 (tally restarted at 0).
- Randomized long run: 10k random pixels with periodic blanking, against a reference model → bit-exact match; |tally|≤10 always; reset asserted mid-burst restores reset values.
